ps2_hex_entry: RTL and testbench

//  Converts PS/2 set-2 scan-code bytes into a 4-digit hex operand for the calculator.

---
 rtl/ps2_hex_entry_if.sv | 27 ++
 rtl/ps2_hex_entry.sv | 184 ++++++++++++++++++
 tb/tb_ps2_hex_entry.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_hex_entry_if.sv
// Scan-byte input and display/operand outputs of ps2_hex_entry.
// master: keyboard/consumer side; slave: ps2_hex_entry itself.
interface ps2_hex_entry_if #(
    parameter int W = 16
);
    logic [7:0]   scan_code;
    logic         scan_valid;
    logic [W-1:0] displayed_number;
    logic         display_sel;
    logic         dp;
    logic [W-1:0] operand;
    logic         operand_valid;
    logic [2:0]   digit_count;
    logic         overflow;

    modport master (
        output scan_code, scan_valid,
        input  displayed_number, display_sel, dp,
        input  operand, operand_valid, digit_count, overflow
    );

    modport slave (
        input  scan_code, scan_valid,
        output displayed_number, display_sel, dp,
        output operand, operand_valid, digit_count, overflow
    );
endinterface

// File: rtl/ps2_hex_entry.sv
// PS/2 set-2 scan codes -> hex operand entry (digits, backspace, esc, enter).
// Ports: clk, reset (sync, active high), bus (ps2_hex_entry_if.slave).
module ps2_hex_entry #(
    parameter int MAX_DIGITS = 4,
    parameter int KEYPAD_EN  = 1
) (
    input logic            clk,
    input logic            reset,
    ps2_hex_entry_if.slave bus
);
    localparam int W = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_BKSP, K_ENTER, K_ESC} key_t;

    state_t       state, state_n;
    key_t         key;
    logic [3:0]   kd;
    logic         make;
    logic         boot;
    logic [W-1:0] value, value_n;
    logic [2:0]   count, count_n;
    logic         fresh, fresh_n;
    logic [W-1:0] disp, disp_n;
    logic         sel, sel_n;
    logic [W-1:0] op, op_n;
    logic         opv, opv_n;
    logic         ovf, ovf_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            boot  <= 1'b1;
            value <= '0;
            count <= '0;
            fresh <= 1'b0;
            disp  <= '0;
            sel   <= 1'b0;
            op    <= '0;
            opv   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            boot  <= 1'b0;
            value <= value_n;
            count <= count_n;
            fresh <= fresh_n;
            disp  <= disp_n;
            sel   <= sel_n;
            op    <= op_n;
            opv   <= opv_n;
            ovf   <= ovf_n;
        end
    end

    // Prefix tracking and make-code decode
    always_comb begin
        state_n = state;
        make    = 1'b0;
        key     = K_NONE;
        kd      = 4'h0;
        if (bus.scan_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.scan_code == 8'hF0)
                        state_n = BRK;
                    else if (bus.scan_code == 8'hE0)
                        state_n = EXT;
                    else
                        make = 1'b1;
                end
                BRK: state_n = IDLE;
                EXT: begin
                    if (bus.scan_code == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else begin
                        state_n = IDLE;
                        if (bus.scan_code == 8'h5A)
                            key = K_ENTER;
                    end
                end
                EXT_BRK: state_n = IDLE;
            endcase
        end
        if (make) begin
            key = K_DIGIT;
            case (bus.scan_code)
                8'h45: kd = 4'h0;
                8'h16: kd = 4'h1;
                8'h1E: kd = 4'h2;
                8'h26: kd = 4'h3;
                8'h25: kd = 4'h4;
                8'h2E: kd = 4'h5;
                8'h36: kd = 4'h6;
                8'h3D: kd = 4'h7;
                8'h3E: kd = 4'h8;
                8'h46: kd = 4'h9;
                8'h1C: kd = 4'hA;
                8'h32: kd = 4'hB;
                8'h21: kd = 4'hC;
                8'h23: kd = 4'hD;
                8'h24: kd = 4'hE;
                8'h2B: kd = 4'hF;
                8'h70: kd = 4'h0;
                8'h69: kd = 4'h1;
                8'h72: kd = 4'h2;
                8'h7A: kd = 4'h3;
                8'h6B: kd = 4'h4;
                8'h73: kd = 4'h5;
                8'h74: kd = 4'h6;
                8'h6C: kd = 4'h7;
                8'h75: kd = 4'h8;
                8'h7D: kd = 4'h9;
                8'h66: key = K_BKSP;
                8'h5A: key = K_ENTER;
                8'h76: key = K_ESC;
                default: key = K_NONE;
            endcase
            // keypad block is 0x69..0x7D; none of the main keys live there
            if (KEYPAD_EN == 0 && key == K_DIGIT &&
                bus.scan_code >= 8'h69 && bus.scan_code <= 8'h7D)
                key = K_NONE;
        end
    end

    // Entry buffer update; the post-reset load rides on boot
    always_comb begin
        value_n = value;
        count_n = count;
        fresh_n = fresh;
        disp_n  = disp;
        sel_n   = boot;
        op_n    = op;
        opv_n   = 1'b0;
        ovf_n   = 1'b0;
        case (key)
            K_DIGIT: begin
                if (fresh) begin
                    value_n = {{(W-4){1'b0}}, kd};
                    count_n = 3'd1;
                    fresh_n = 1'b0;
                    sel_n   = 1'b1;
                end else if (count < 3'(MAX_DIGITS)) begin
                    value_n = {value[W-5:0], kd};
                    count_n = count + 3'd1;
                    sel_n   = 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
                disp_n = value_n;
            end
            K_BKSP, K_ESC: begin
                // backspace right after a commit clears like Esc
                if (key == K_ESC || fresh) begin
                    value_n = '0;
                    count_n = '0;
                    fresh_n = 1'b0;
                    disp_n  = '0;
                    sel_n   = 1'b1;
                end else if (count != 3'd0) begin
                    value_n = value >> 4;
                    count_n = count - 3'd1;
                    disp_n  = value_n;
                    sel_n   = 1'b1;
                end
            end
            K_ENTER: begin
                op_n    = value;
                opv_n   = 1'b1;
                fresh_n = 1'b1;
                count_n = '0;
            end
            default: ;
        endcase
    end

    assign bus.displayed_number = disp;
    assign bus.display_sel      = sel;
    assign bus.dp               = fresh;
    assign bus.operand          = op;
    assign bus.operand_valid    = opv;
    assign bus.digit_count      = count;
    assign bus.overflow         = ovf;
endmodule

// File: tb/tb_ps2_hex_entry.sv
// Randomized self-checking bench for ps2_hex_entry against a digit-queue model.
// Drives scan bytes through ps2_hex_entry_if; checks every output every cycle.
module tb_ps2_hex_entry;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    ps2_hex_entry_if #(.W(16)) bus ();

    ps2_hex_entry dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int q[$];
    bit m_fresh, m_skip, m_ext;
    logic [15:0] e_disp, e_op;
    bit e_sel, e_opv, e_ovf;

    logic [7:0] main_codes[16] = '{8'h45, 8'h16, 8'h1E, 8'h26,
        8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C,
        8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    logic [7:0] kp_codes[10] = '{8'h70, 8'h69, 8'h72, 8'h7A,
        8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] pool[8] = '{8'hF0, 8'hE0, 8'h5A, 8'h66,
        8'h76, 8'h66, 8'h11, 8'hF0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++)
            if (main_codes[i] == b) return i;
        for (int i = 0; i < 10; i++)
            if (kp_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [15:0] q_val();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return 16'(v);
    endfunction

    task automatic m_clear();
        q.delete();
        m_fresh = 0;
        e_disp = 16'h0;
        e_sel = 1;
    endtask

    task automatic m_enter();
        e_op = q_val();
        e_opv = 1;
        m_fresh = 1;
    endtask

    task automatic model(input logic [7:0] b);
        int d;
        if (m_skip) begin
            m_skip = 0;
            return;
        end
        if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_skip = 1;
            else if (b == 8'h5A) m_enter();
            return;
        end
        if (b == 8'hF0) begin m_skip = 1; return; end
        if (b == 8'hE0) begin m_ext = 1; return; end
        d = digit_of(b);
        if (d >= 0) begin
            if (m_fresh) begin
                q.delete();
                m_fresh = 0;
            end
            if (q.size() < 4) begin
                q.push_back(d);
                e_disp = q_val();
                e_sel = 1;
            end else begin
                e_ovf = 1;
            end
        end else if (b == 8'h76) begin
            m_clear();
        end else if (b == 8'h66) begin
            if (m_fresh) m_clear();
            else if (q.size() > 0) begin
                void'(q.pop_back());
                e_disp = q_val();
                e_sel = 1;
            end
        end else if (b == 8'h5A) begin
            m_enter();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".disp"}, bus.displayed_number, e_disp);
        chk({tag, ".sel"}, bus.display_sel, e_sel);
        chk({tag, ".dp"}, bus.dp, m_fresh);
        chk({tag, ".op"}, bus.operand, e_op);
        chk({tag, ".opv"}, bus.operand_valid, e_opv);
        chk({tag, ".cnt"}, bus.digit_count, m_fresh ? 0 : q.size());
        chk({tag, ".ovf"}, bus.overflow, e_ovf);
    endtask

    task automatic step(input string tag, input bit v,
                        input logic [7:0] b);
        @(negedge clk);
        bus.scan_valid = v;
        bus.scan_code = b;
        e_sel = 0;
        e_opv = 0;
        e_ovf = 0;
        if (v) model(b);
        @(posedge clk);
        #1 check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        bus.scan_valid = 0;
        q.delete();
        m_fresh = 0;
        m_skip = 0;
        m_ext = 0;
        e_disp = 0;
        e_op = 0;
        e_sel = 0;
        e_opv = 0;
        e_ovf = 0;
        @(posedge clk);
        #1 check_all("rst");
        @(negedge clk);
        reset = 0;
        e_sel = 1;
        @(posedge clk);
        #1 check_all("boot");
    endtask

    initial begin
        bus.scan_valid = 0;
        bus.scan_code = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();
        send("t1", 8'h16);
        send("t1", 8'h1E);
        send("t1", 8'h26);
        send("t1", 8'h25);
        chk("t1_val", bus.displayed_number, 16'h1234);
        send("t2", 8'h1C);
        chk("t2_ovf", bus.overflow, 1);
        send("t2", 8'hF0);
        send("t2", 8'h1C);
        send("t3", 8'h66);
        send("t3", 8'h66);
        chk("t3_val", bus.displayed_number, 16'h0012);
        send("t3", 8'h5A);
        chk("t3_op", bus.operand, 16'h0012);
        send("t3", 8'h5A);
        send("t4", 8'h2B);
        chk("t4_val", bus.displayed_number, 16'h000F);
        send("t4", 8'hE0);
        send("t4", 8'h5A);
        chk("t4_op", bus.operand, 16'h000F);
        send("t5", 8'h45);
        send("t5", 8'h7A);
        send("t5", 8'hF0);
        do_reset();
        send("t5", 8'h26);
        chk("t5_val", bus.displayed_number, 16'h0003);
        send("t6", 8'h26);
        send("t6", 8'h25);
        send("t6", 8'h76);
        chk("t6_cnt", bus.digit_count, 0);
        send("t6", 8'h11);
        step("idle", 1'b0, 8'h16);
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else if (r < 12) step("rnd", 1'b0, 8'($urandom));
            else if (r < 45) send("rnd", main_codes[$urandom_range(0, 15)]);
            else if (r < 55) send("rnd", kp_codes[$urandom_range(0, 9)]);
            else if (r < 90) send("rnd", pool[$urandom_range(0, 7)]);
            else send("rnd", 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
